pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised inter-stage pipeline register chain for the MIPS core; replaces per-boundary registers.
//  STAGES back-to-back slots carry payload, PC, A3/RFWr, Tnew, ExcCode and BD from one pipeline stage onward.
//  Supports hold, stall-bubble and exception-flush control, saturating Tnew countdown, and per-slot hazard view for forwarding.
// PARAMETERS
//  DATA_W   96            packed payload width (e.g. Instr|AO|V2)
//  STAGES   1             number of register slots in the chain (1..4)
//  TNEW_W   2             Tnew field width
//  EXC_W    5             exception-code width
//  INIT_PC  32'h0000_3000 PC value held by reset/bubble slots
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high reset
//  req        in   1               exception/interrupt flush: every slot becomes a bubble
//  hold       in   1               freeze entire chain (e.g. multiply-busy or bus wait)
//  stall      in   1               slot 0 loads a bubble, slots 1..STAGES-1 still advance
//  in_valid   in   1               input carries a real instruction
//  in_data    in   DATA_W          payload
//  in_pc      in   32              instruction PC
//  in_a3      in   5               destination register
//  in_rfwr    in   1               register-write enable
//  in_tnew    in   TNEW_W          cycles until result ready, measured at input
//  in_exc     in   EXC_W           exception code, 0 = none
//  in_bd      in   1               instruction is in a branch delay slot
//  out_valid/out_data/out_pc/out_a3/out_rfwr/out_tnew/out_exc/out_bd  out  (as inputs)  last slot
//  stg_a3     out  5*STAGES        A3 of every slot, slot 0 at LSBs (forwarding/hazard)
//  stg_rfwr   out  STAGES          RFWr of every slot
//  stg_tnew   out  TNEW_W*STAGES   Tnew of every slot
// BEHAVIOUR
//  - Bubble: valid=0, data=0, a3=0, rfwr=0, tnew=0, exc=0, bd=0, pc=INIT_PC.
//  - Reset (async, immediate): every slot = bubble; all outputs show bubble values, out_pc=INIT_PC.
//  - Per posedge, priority req > hold > stall > normal:
//    req:   all slots <= bubble, regardless of hold/stall.
//    hold:  all slots keep value; Tnew NOT decremented.
//    stall: slot0 <= bubble; slot k <= slot k-1 (k>=1).
//    normal: slot0 <= input; slot k <= slot k-1.
//  - Tnew: sat_dec(x) = (x==0)?0:x-1. On load slot0.tnew = sat_dec(in_tnew); on shift slot k.tnew = sat_dec(slot k-1.tnew).
//    Therefore slot k holds in_tnew-(k+1) saturated at 0; never wraps.
//  - Excepting instruction: if in_exc!=0 on load, slot0.rfwr forced 0 (a3, exc, pc, bd kept).
//  - in_valid=0 loads as bubble except PC/BD (see macro); in_rfwr ignored when in_valid=0.
//  - Latency: input visible at out_* exactly STAGES un-held cycles later. No combinational input->output path.
//  - stg_* reflect registered slot contents only.
//  - reset asserted mid-hold or mid-stall: reset wins instantly; first post-reset edge behaves per control inputs.
// CONFIGURATION
//  PIPE_BUBBLE_PC_KEEP_EN
//   defined:   stall bubble takes pc=in_pc, bd=in_bd; in_valid=0 load keeps in_pc/in_bd; req bubbles keep
//              each slot's own pc/bd (macroscopic PC for CP0 EPC stays meaningful). Other fields as bubble.
//   undefined: all bubbles use pc=INIT_PC, bd=0.
//   reset always gives INIT_PC/bd=0 in both builds.
// TESTING
//  1 STAGES=1: reset, load pc=0x3004 a3=5 rfwr=1 tnew=2 -> next edge out_pc=0x3004 out_a3=5 out_tnew=1; tnew=0 in -> out_tnew=0.
//  2 STAGES=3: load tnew=3, no controls -> stg_tnew slot0/1/2 = 2,1,0 on successive edges; out appears after 3 edges.
//  3 hold 2 cycles with slot0.tnew=2 -> tnew stays 2, all slots unchanged; release -> advance resumes, tnew=1.
//  4 stall with in_pc=0x3010 in_bd=1 -> slot0 valid=0 rfwr=0; pc=0x3000 bd=0 (macro off) / pc=0x3010 bd=1 (macro on); slot1 advances.
//  5 req together with hold and stall, chain full -> all slots bubble next edge, stg_rfwr=0; in_exc=5'd4 load -> rfwr=0, exc=4.
//  6 assert reset between edges with chain full -> outputs bubble immediately (out_pc=0x3000), no clock needed.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: STAGES-deep inter-stage register chain with flush/hold/stall control,
// saturating Tnew countdown and per-slot hazard view. Optional macro: PIPE_BUBBLE_PC_KEEP_EN.
module pipe_stage_chain #(
  parameter int unsigned DATA_W  = 96,
  parameter int unsigned STAGES  = 1,
  parameter int unsigned TNEW_W  = 2,
  parameter int unsigned EXC_W   = 5,
  parameter logic [31:0] INIT_PC = 32'h0000_3000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req,
  input  logic                       hold,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [31:0]                in_pc,
  input  logic [4:0]                 in_a3,
  input  logic                       in_rfwr,
  input  logic [TNEW_W-1:0]          in_tnew,
  input  logic [EXC_W-1:0]           in_exc,
  input  logic                       in_bd,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_a3,
  output logic                       out_rfwr,
  output logic [TNEW_W-1:0]          out_tnew,
  output logic [EXC_W-1:0]           out_exc,
  output logic                       out_bd,
  output logic [5*STAGES-1:0]        stg_a3,
  output logic [STAGES-1:0]          stg_rfwr,
  output logic [TNEW_W*STAGES-1:0]   stg_tnew
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic [4:0]        a3;
    logic              rfwr;
    logic [TNEW_W-1:0] tnew;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } slot_t;

  function automatic slot_t bubble();
    slot_t s;
    s    = '0;
    s.pc = INIT_PC;
    return s;
  endfunction

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  slot_t idle_slot;
  slot_t load_slot;
  slot_t head_feed;
  slot_t slot_q [STAGES];

  // idle_slot is both the stall bubble and the in_valid=0 load.
  always_comb begin
    idle_slot = bubble();
`ifdef PIPE_BUBBLE_PC_KEEP_EN
    idle_slot.pc = in_pc;
    idle_slot.bd = in_bd;
`endif
    load_slot = idle_slot;
    if (in_valid) begin
      load_slot.valid = 1'b1;
      load_slot.data  = in_data;
      load_slot.pc    = in_pc;
      load_slot.a3    = in_a3;
      load_slot.rfwr  = in_rfwr && (in_exc == '0);
      load_slot.tnew  = sat_dec(in_tnew);
      load_slot.exc   = in_exc;
      load_slot.bd    = in_bd;
    end
    head_feed = stall ? idle_slot : load_slot;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    slot_t feed;
    slot_t nxt;
    slot_t q;

    if (g == 0) begin : g_head
      assign feed = head_feed;
    end else begin : g_body
      always_comb begin
        feed      = slot_q[g-1];
        feed.tnew = sat_dec(slot_q[g-1].tnew);
      end
    end

    always_comb begin
      nxt = feed;
      if (req) begin
        nxt = bubble();
`ifdef PIPE_BUBBLE_PC_KEEP_EN
        nxt.pc = q.pc;
        nxt.bd = q.bd;
`endif
      end else if (hold) begin
        nxt = q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= bubble();
      else       q <= nxt;
    end

    assign slot_q[g]                    = q;
    assign stg_a3[5*g +: 5]             = q.a3;
    assign stg_rfwr[g]                  = q.rfwr;
    assign stg_tnew[TNEW_W*g +: TNEW_W] = q.tnew;
  end

  assign out_valid = slot_q[STAGES-1].valid;
  assign out_data  = slot_q[STAGES-1].data;
  assign out_pc    = slot_q[STAGES-1].pc;
  assign out_a3    = slot_q[STAGES-1].a3;
  assign out_rfwr  = slot_q[STAGES-1].rfwr;
  assign out_tnew  = slot_q[STAGES-1].tnew;
  assign out_exc   = slot_q[STAGES-1].exc;
  assign out_bd    = slot_q[STAGES-1].bd;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a 1-slot and a 3-slot instance share stimulus; default build (macro off).
module tb_pipe_stage_chain;
  localparam int DW = 96;
  localparam int TW = 2;
  localparam int EW = 5;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic [31:0]   pc;
    logic [4:0]    a3;
    logic          rfwr;
    logic [TW-1:0] tnew;
    logic [EW-1:0] exc;
    logic          bd;
  } rec_t;

  logic clk = 1'b0;
  logic reset, req, hold, stall, in_valid, in_rfwr, in_bd;
  logic [DW-1:0] in_data;
  logic [31:0]   in_pc;
  logic [4:0]    in_a3;
  logic [TW-1:0] in_tnew;
  logic [EW-1:0] in_exc;

  logic o1_valid, o1_rfwr, o1_bd, o3_valid, o3_rfwr, o3_bd;
  logic [DW-1:0] o1_data, o3_data;
  logic [31:0]   o1_pc, o3_pc;
  logic [4:0]    o1_a3, o3_a3;
  logic [TW-1:0] o1_tnew, o3_tnew;
  logic [EW-1:0] o1_exc, o3_exc;
  logic [4:0]    s1_a3;
  logic [0:0]    s1_rfwr;
  logic [1:0]    s1_tnew;
  logic [14:0]   s3_a3;
  logic [2:0]    s3_rfwr;
  logic [5:0]    s3_tnew;

  rec_t act1, act3;
  assign act1 = {o1_valid, o1_data, o1_pc, o1_a3, o1_rfwr, o1_tnew, o1_exc, o1_bd};
  assign act3 = {o3_valid, o3_data, o3_pc, o3_a3, o3_rfwr, o3_tnew, o3_exc, o3_bd};

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(1), .TNEW_W(TW), .EXC_W(EW), .INIT_PC(32'h0000_3000)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_a3(in_a3), .in_rfwr(in_rfwr),
    .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(o1_valid), .out_data(o1_data), .out_pc(o1_pc), .out_a3(o1_a3), .out_rfwr(o1_rfwr),
    .out_tnew(o1_tnew), .out_exc(o1_exc), .out_bd(o1_bd),
    .stg_a3(s1_a3), .stg_rfwr(s1_rfwr), .stg_tnew(s1_tnew)
  );

  pipe_stage_chain #(.DATA_W(DW), .STAGES(3), .TNEW_W(TW), .EXC_W(EW), .INIT_PC(32'h0000_3000)) u_dut3 (
    .clk(clk), .reset(reset), .req(req), .hold(hold), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_pc(in_pc), .in_a3(in_a3), .in_rfwr(in_rfwr),
    .in_tnew(in_tnew), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(o3_valid), .out_data(o3_data), .out_pc(o3_pc), .out_a3(o3_a3), .out_rfwr(o3_rfwr),
    .out_tnew(o3_tnew), .out_exc(o3_exc), .out_bd(o3_bd),
    .stg_a3(s3_a3), .stg_rfwr(s3_rfwr), .stg_tnew(s3_tnew)
  );

  always #5 clk = ~clk;

  function automatic rec_t bubble_rec();
    rec_t b;
    b    = '0;
    b.pc = 32'h0000_3000;
    return b;
  endfunction

  function automatic rec_t mk(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                              input logic rf, input logic [TW-1:0] tn, input logic [EW-1:0] ex,
                              input logic bd);
    rec_t r;
    r.valid = v; r.data = {pc, ~pc, pc}; r.pc = pc; r.a3 = a3;
    r.rfwr = rf; r.tnew = tn; r.exc = ex; r.bd = bd;
    return r;
  endfunction

  // Expected last-slot view of an input after passing through a chain of the given depth.
  function automatic rec_t expect_out(input rec_t in, input int depth);
    rec_t r;
    if (!in.valid) return bubble_rec();
    r      = in;
    r.rfwr = in.rfwr && (in.exc == '0);
    r.tnew = (int'(in.tnew) > depth) ? TW'(int'(in.tnew) - depth) : '0;
    return r;
  endfunction

  task automatic drive(input rec_t r);
    in_valid = r.valid; in_data = r.data; in_pc = r.pc; in_a3 = r.a3;
    in_rfwr = r.rfwr; in_tnew = r.tnew; in_exc = r.exc; in_bd = r.bd;
  endtask

  task automatic drive_idle();
    req = 1'b0; hold = 1'b0; stall = 1'b0;
    drive('0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    n_tests++; if (act1 !== bubble_rec()) begin n_fail++; $display("FAIL reset_out1: got %h expected %h", act1, bubble_rec()); end
    n_tests++; if (act3 !== bubble_rec()) begin n_fail++; $display("FAIL reset_out3: got %h expected %h", act3, bubble_rec()); end
    n_tests++; if ({s3_a3, s3_rfwr, s3_tnew} !== '0) begin n_fail++; $display("FAIL reset_stg3: got %h expected 0", {s3_a3, s3_rfwr, s3_tnew}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    drive(mk(1'b1, 32'h3004, 5'd5, 1'b1, 2'd2, '0, 1'b0));
    tick();
    n_tests++; if (o1_pc !== 32'h3004) begin n_fail++; $display("FAIL basic_pc: got %h expected %h", o1_pc, 32'h3004); end
    n_tests++; if (o1_a3 !== 5'd5) begin n_fail++; $display("FAIL basic_a3: got %0d expected 5", o1_a3); end
    n_tests++; if (o1_tnew !== 2'd1) begin n_fail++; $display("FAIL basic_tnew: got %0d expected 1", o1_tnew); end
    n_tests++; if (o1_rfwr !== 1'b1 || o1_valid !== 1'b1) begin n_fail++; $display("FAIL basic_vld_rfwr: got %b%b expected 11", o1_valid, o1_rfwr); end
    drive(mk(1'b1, 32'h3008, 5'd6, 1'b1, 2'd0, '0, 1'b0));
    tick();
    n_tests++; if (o1_tnew !== 2'd0) begin n_fail++; $display("FAIL basic_tnew0: got %0d expected 0", o1_tnew); end
    drive_idle();
  endtask

  task automatic test_tnew_chain();
    do_reset();
    drive(mk(1'b1, 32'h3100, 5'd7, 1'b1, 2'd3, '0, 1'b0));
    tick();
    drive_idle();
    n_tests++; if (s3_tnew[1:0] !== 2'd2) begin n_fail++; $display("FAIL chain_tnew_s0: got %0d expected 2", s3_tnew[1:0]); end
    n_tests++; if (o3_valid !== 1'b0) begin n_fail++; $display("FAIL chain_early1: got %b expected 0", o3_valid); end
    tick();
    n_tests++; if (s3_tnew[3:2] !== 2'd1 || s3_a3[9:5] !== 5'd7) begin n_fail++; $display("FAIL chain_s1: got tnew %0d a3 %0d expected 1 7", s3_tnew[3:2], s3_a3[9:5]); end
    n_tests++; if (o3_valid !== 1'b0) begin n_fail++; $display("FAIL chain_early2: got %b expected 0", o3_valid); end
    tick();
    n_tests++; if (s3_tnew[5:4] !== 2'd0) begin n_fail++; $display("FAIL chain_tnew_s2: got %0d expected 0", s3_tnew[5:4]); end
    n_tests++; if (o3_valid !== 1'b1 || o3_a3 !== 5'd7 || o3_pc !== 32'h3100) begin n_fail++; $display("FAIL chain_out: got v%b a3 %0d pc %h expected v1 a3 7 pc 3100", o3_valid, o3_a3, o3_pc); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(mk(1'b1, 32'h3200, 5'd9, 1'b1, 2'd3, '0, 1'b0));
    tick();
    hold = 1'b1;
    drive(mk(1'b1, 32'h3204, 5'd1, 1'b1, 2'd3, '0, 1'b0));
    tick();
    tick();
    n_tests++; if (s3_tnew !== 6'b00_00_10) begin n_fail++; $display("FAIL hold_tnew: got %b expected 000010", s3_tnew); end
    n_tests++; if (s3_a3 !== {5'd0, 5'd0, 5'd9} || s3_rfwr !== 3'b001) begin n_fail++; $display("FAIL hold_slots: got a3 %h rfwr %b expected 0009 001", s3_a3, s3_rfwr); end
    drive_idle();
    tick();
    n_tests++; if (s3_tnew[3:2] !== 2'd1 || s3_a3[9:5] !== 5'd9 || s3_a3[4:0] !== 5'd0) begin n_fail++; $display("FAIL hold_release: got tnew1 %0d a3 %h expected 1 a3 slot1 9", s3_tnew[3:2], s3_a3); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(mk(1'b1, 32'h3020, 5'd3, 1'b1, 2'd2, '0, 1'b0));
    tick();
    stall = 1'b1;
    drive(mk(1'b1, 32'h3010, 5'd6, 1'b1, 2'd2, '0, 1'b1));
    tick();
    n_tests++; if (s3_rfwr !== 3'b010 || s3_a3[4:0] !== 5'd0 || s3_a3[9:5] !== 5'd3) begin n_fail++; $display("FAIL stall_slots: got rfwr %b a3 %h expected 010 slot1 a3 3", s3_rfwr, s3_a3); end
    n_tests++; if (s3_tnew[3:2] !== 2'd0) begin n_fail++; $display("FAIL stall_tnew1: got %0d expected 0", s3_tnew[3:2]); end
    n_tests++; if (o1_valid !== 1'b0 || o1_rfwr !== 1'b0 || o1_pc !== 32'h3000 || o1_bd !== 1'b0) begin n_fail++; $display("FAIL stall_bubble: got v%b rf%b pc %h bd%b expected v0 rf0 pc 3000 bd0", o1_valid, o1_rfwr, o1_pc, o1_bd); end
    drive_idle();
  endtask

  task automatic test_req();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(mk(1'b1, 32'h3300 + 32'(4*i), 5'(i), 1'b1, 2'd3, '0, 1'b0));
      tick();
    end
    n_tests++; if (s3_rfwr !== 3'b111) begin n_fail++; $display("FAIL req_full: got %b expected 111", s3_rfwr); end
    req = 1'b1; hold = 1'b1; stall = 1'b1;
    tick();
    n_tests++; if (s3_rfwr !== 3'b000 || s3_a3 !== '0) begin n_fail++; $display("FAIL req_stg: got rfwr %b a3 %h expected 000 0", s3_rfwr, s3_a3); end
    n_tests++; if (act3 !== bubble_rec()) begin n_fail++; $display("FAIL req_out3: got %h expected %h", act3, bubble_rec()); end
    n_tests++; if (act1 !== bubble_rec()) begin n_fail++; $display("FAIL req_out1: got %h expected %h", act1, bubble_rec()); end
    req = 1'b0; hold = 1'b0; stall = 1'b0;
    drive(mk(1'b1, 32'h3040, 5'd12, 1'b1, 2'd1, 5'd4, 1'b0));
    tick();
    n_tests++; if (o1_rfwr !== 1'b0 || o1_exc !== 5'd4 || o1_a3 !== 5'd12 || o1_pc !== 32'h3040 || o1_valid !== 1'b1) begin n_fail++; $display("FAIL exc_load: got rf%b exc %0d a3 %0d pc %h v%b expected rf0 exc 4 a3 12 pc 3040 v1", o1_rfwr, o1_exc, o1_a3, o1_pc, o1_valid); end
    n_tests++; if (s3_rfwr[0] !== 1'b0) begin n_fail++; $display("FAIL exc_stg: got %b expected 0", s3_rfwr[0]); end
    drive_idle();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(mk(1'b1, 32'h3400 + 32'(4*i), 5'(16 + i), 1'b1, 2'd3, '0, 1'b1));
      tick();
    end
    hold = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    n_tests++; if (o3_pc !== 32'h3000 || o3_valid !== 1'b0 || s3_rfwr !== 3'b000) begin n_fail++; $display("FAIL async_reset3: got pc %h v%b rfwr %b expected 3000 0 000", o3_pc, o3_valid, s3_rfwr); end
    n_tests++; if (act1 !== bubble_rec()) begin n_fail++; $display("FAIL async_reset1: got %h expected %h", act1, bubble_rec()); end
    reset = 1'b0;
    hold = 1'b0;
    drive(mk(1'b1, 32'h3500, 5'd21, 1'b1, 2'd2, '0, 1'b0));
    tick();
    n_tests++; if (s3_a3[4:0] !== 5'd21 || s3_a3[14:5] !== '0) begin n_fail++; $display("FAIL post_reset_edge: got %h expected slot0 a3 21 only", s3_a3); end
    drive_idle();
  endtask

  task automatic test_stream();
    rec_t q1[$];
    rec_t q3[$];
    rec_t r, e1, e3;
    do_reset();
    q3.push_back(bubble_rec());
    q3.push_back(bubble_rec());
    for (int c = 0; c < 40; c++) begin
      r.valid = ($urandom_range(0, 3) != 0);
      r.data  = {$urandom(), $urandom(), $urandom()};
      r.pc    = $urandom() & 32'hFFFF_FFFC;
      r.a3    = 5'($urandom());
      r.rfwr  = 1'($urandom());
      r.tnew  = TW'($urandom());
      r.exc   = ($urandom_range(0, 4) == 0) ? EW'($urandom_range(1, 31)) : '0;
      r.bd    = 1'($urandom());
      drive(r);
      q1.push_back(expect_out(r, 1));
      q3.push_back(expect_out(r, 3));
      tick();
      e1 = q1.pop_front();
      e3 = q3.pop_front();
      n_tests++; if (act1 !== e1) begin n_fail++; $display("FAIL stream1 c%0d: got %h expected %h", c, act1, e1); end
      n_tests++; if (act3 !== e3) begin n_fail++; $display("FAIL stream3 c%0d: got %h expected %h", c, act3, e3); end
    end
    drive_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_tnew_chain();
    test_hold();
    test_stall();
    test_req();
    test_async_reset();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
